// File: rtl/ahbl_arbiter_2.sv
// Two-master AHB-Lite arbiter: shares one downstream bus between M0 and M1,
// parking the losing master's address phase in a pending register for replay.
module ahbl_arbiter_2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    output logic [1:0]  OWNER
);

    logic [1:0]  r_pend_valid;
    logic [31:0] r_pend_addr0, r_pend_addr1;
    logic [2:0]  r_pend_size0, r_pend_size1;
    logic        r_pend_write0, r_pend_write1;
    logic        r_dph_valid;
    logic        r_dph_owner;
    logic        r_last_grant;

    logic [1:0]  w_live;
    logic [1:0]  w_req;
    logic        w_grant;
    logic        w_win;
    logic        w_from_pend;
    logic        w_accept;

    // Master ready never looks at its own HTRANS, only at pending/data-phase state.
    always_comb begin
        M0_HREADY = 1'b1;
        M1_HREADY = 1'b1;
        if (r_pend_valid[0])
            M0_HREADY = 1'b0;
        else if (r_dph_valid && !r_dph_owner)
            M0_HREADY = HREADY;
        if (r_pend_valid[1])
            M1_HREADY = 1'b0;
        else if (r_dph_valid && r_dph_owner)
            M1_HREADY = HREADY;
    end

    assign w_live[0] = M0_HREADY & M0_HTRANS[1];
    assign w_live[1] = M1_HREADY & M1_HTRANS[1];
    assign w_req     = (r_pend_valid | w_live) & {2{~HRESET}};
    assign w_grant   = |w_req;

    always_comb begin
        w_win = 1'b0;
        case (w_req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = FIXED_PRIO ? 1'b0 : ~r_last_grant;
            default: w_win = 1'b0;
        endcase
    end

    assign w_from_pend = r_pend_valid[w_win];
    assign w_accept    = w_grant & HREADY;

    always_comb begin
        HADDR  = 32'h0;
        HSIZE  = 3'b000;
        HWRITE = 1'b0;
        HTRANS = 2'b00;
        if (w_grant) begin
            HTRANS = 2'b10;
            if (!w_win) begin
                HADDR  = w_from_pend ? r_pend_addr0  : M0_HADDR;
                HSIZE  = w_from_pend ? r_pend_size0  : M0_HSIZE;
                HWRITE = w_from_pend ? r_pend_write0 : M0_HWRITE;
            end else begin
                HADDR  = w_from_pend ? r_pend_addr1  : M1_HADDR;
                HSIZE  = w_from_pend ? r_pend_size1  : M1_HSIZE;
                HWRITE = w_from_pend ? r_pend_write1 : M1_HWRITE;
            end
        end
    end

    assign HWDATA    = r_dph_owner ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign OWNER     = {r_dph_valid, r_dph_owner};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend_valid  <= 2'b00;
            r_pend_addr0  <= 32'h0;
            r_pend_addr1  <= 32'h0;
            r_pend_size0  <= 3'b000;
            r_pend_size1  <= 3'b000;
            r_pend_write0 <= 1'b0;
            r_pend_write1 <= 1'b0;
            r_dph_valid   <= 1'b0;
            r_dph_owner   <= 1'b0;
            r_last_grant  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_dph_valid  <= 1'b1;
                r_dph_owner  <= w_win;
                r_last_grant <= w_win;
                if (w_from_pend)
                    r_pend_valid[w_win] <= 1'b0;
            end else if (HREADY) begin
                r_dph_valid <= 1'b0;
            end
            // A live request implies its pending slot is empty, so no clash with the clear above.
            if (w_live[0] && !(w_accept && !w_win)) begin
                r_pend_valid[0] <= 1'b1;
                r_pend_addr0    <= M0_HADDR;
                r_pend_size0    <= M0_HSIZE;
                r_pend_write0   <= M0_HWRITE;
            end
            if (w_live[1] && !(w_accept && w_win)) begin
                r_pend_valid[1] <= 1'b1;
                r_pend_addr1    <= M1_HADDR;
                r_pend_size1    <= M1_HSIZE;
                r_pend_write1   <= M1_HWRITE;
            end
        end
    end

endmodule

// File: doc/ahbl_arbiter_2.md
# ahbl_arbiter_2

Two-master AHB-Lite arbiter that shares the single system bus between the Hazard2 CPU (M0) and a second bus master such as a DMA or accelerator (M1). It sits between the masters and the address splitter. It presents one AHB-Lite master interface downstream and two slave-facing interfaces upstream. When both masters contend, the losing master's address phase is captured and replayed, so no transfer is dropped.

## Interface
Parameters:
- FIXED_PRIO, 0 — arbitration policy: 0 = round-robin, 1 = M0 always wins contention.

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- M0_HADDR / M1_HADDR  in  32  master address.
- M0_HTRANS / M1_HTRANS  in  2  transfer type; bit 1 set = transfer request.
- M0_HSIZE / M1_HSIZE  in  3  transfer size.
- M0_HWRITE / M1_HWRITE  in  1  write flag.
- M0_HWDATA / M1_HWDATA  in  32  write data.
- M0_HREADY / M1_HREADY  out  1  per-master ready/stall.
- M0_HRDATA / M1_HRDATA  out  32  read data, broadcast from HRDATA.
- HADDR, HSIZE, HWRITE  out  32/3/1  downstream address-phase signals.
- HTRANS  out  2  downstream transfer type: 2'b10 or 2'b00 only.
- HWDATA  out  32  downstream write data, muxed by data-phase owner.
- HREADY  in  1  downstream ready, from splitter.
- HRDATA  in  32  downstream read data.
- OWNER  out  2  debug: {dph_valid, dph_owner}.

## Operation
- **Per-master pending register.** Holds pend_valid, addr, size, write.
- **Request of Mx.** Asserted when pend_valid[x] is set, or when Mx_HREADY=1 and Mx_HTRANS[1]=1 (live request).
- **Grant.** Evaluated combinationally every cycle among active requests.
  - Single requester wins.
  - Contention with FIXED_PRIO=1: M0 wins.
  - Contention with FIXED_PRIO=0: the master other than last_grant wins.
- **Downstream address phase.**
  - HADDR/HSIZE/HWRITE come from the winner: from its pending register if pend_valid is set, otherwise live.
  - HTRANS=2'b10 when a grant exists, else 2'b00 with HADDR=0.
  - Incoming SEQ is forwarded as NONSEQ; bursts are not kept atomic.
- **Acceptance.** The address phase is accepted at an edge when a grant exists and HREADY=1. On acceptance:
  - dph_valid←1, dph_owner←winner, last_grant←winner.
  - pend_valid[winner]←0 if the grant was taken from the pending register.
- **Data phase end.** At an HREADY=1 edge with no grant, dph_valid←0.
- **Capture.** Mx's live address phase is captured into its pending register at an edge where Mx_HREADY=1, Mx_HTRANS[1]=1, and it was not accepted. This happens when Mx lost arbitration or when HREADY=0.
- **Mx_HREADY rules.**
  - pend_valid[x]=1 → 0.
  - Else if dph_valid and dph_owner=x → HREADY.
  - Else → 1.
- **HWDATA.** Equals M{dph_owner}_HWDATA. A captured master holds HWDATA stable while stalled, per AHB-Lite.
- **Reset values.** pend_valid=00, dph_valid=0, last_grant=M1 (so M0 wins the first tie). Outputs: HTRANS=00, HADDR=0, M0_HREADY=M1_HREADY=1, OWNER=00.
- **Reset mid-operation.** The synchronous clear discards pending and in-flight transfers. No downstream transfer is issued in the reset cycle.

## Timing
- **Uncontended.** Zero added latency: the address path is combinational from master to downstream in the same cycle.
- **Contended.** The loser's transfer is captured at edge N and issued at N+1 at the earliest. Its data phase completes at N+2 at the earliest, a minimum of one extra stall cycle.
- **Wait states.** A downstream HREADY=0 stalls the data-phase owner. It also causes capture of any live request from the other master that is presented with its HREADY=1.
- **Round-robin fairness.** Under continuous contention grants strictly alternate, so neither master waits more than one transfer.
- **Combinational paths.** HREADY→Mx_HREADY is combinational; no path runs from Mx_HTRANS to Mx_HREADY.

## Test plan
- **Solo M0.** M0 reads 0x2000_0010 with HREADY=1 → HADDR=0x2000_0010 and HTRANS=10 in the same cycle; M0_HREADY=1; M0_HRDATA=HRDATA next cycle; M1_HREADY=1 throughout.
- **Same-cycle contention, round-robin, post-reset.** M0 writes 0x4000_0000 and M1 writes 0x2000_0004 → M0 is granted first. M1 is captured, M1_HREADY=0 for one cycle, and 0x2000_0004 issues the next cycle. HWDATA carries M0 data, then M1 data.
- **Continuous contention, FIXED_PRIO=0.** 6 back-to-back requests each → grants alternate M0,M1,M0,M1… FIXED_PRIO=1 → M0 gets all 6 before M1's single pending transfer issues.
- **Downstream wait states.** HREADY=0 for 3 cycles during an M1 data phase while M0 requests 0x0000_0100 → M0 is captured. HADDR=0x0000_0100 appears on the first HREADY=1 cycle. M0_HWDATA is held and forwarded correctly.
- **Reset mid-operation.** Assert HRESET with pend_valid=11 and dph_valid=1 → next cycle pend_valid=00, HTRANS=00, M0_HREADY=M1_HREADY=1, OWNER=00; the first post-reset tie goes to M0.
